// File: rtl/parking_gate_if.sv
// Signals between the loop detectors / occupancy counter and the gate controller.
// Event counter outputs exist only when PARKING_GATE_EVENT_COUNT_EN is defined.
interface parking_gate_if
`ifdef PARKING_GATE_EVENT_COUNT_EN
    #(parameter int CNT_W = 16)
`endif
    ;
    logic       entry_sense;
    logic       entry_uni_tag;
    logic       exit_sense;
    logic       exit_uni_tag;
    logic       uni_is_vacated_space;
    logic       is_vacated_space;
    // Event outputs are one-cycle strobes with no back-pressure: the consumer
    // must take each pulse in the cycle it is high; tags are valid only then.
    logic       car_entered;
    logic       is_uni_car_entered;
    logic       car_exited;
    logic       is_uni_car_exited;
    logic       entry_barrier_open;
    logic       exit_barrier_open;
    logic       entry_reject;
    logic [2:0] entry_state_dbg;
    logic [1:0] exit_state_dbg;
`ifdef PARKING_GATE_EVENT_COUNT_EN
    logic [CNT_W-1:0] n_entered;
    logic [CNT_W-1:0] n_exited;
    logic [CNT_W-1:0] n_rejected;
`endif

    modport master (
        output entry_sense, entry_uni_tag, exit_sense, exit_uni_tag,
        output uni_is_vacated_space, is_vacated_space,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  entry_barrier_open, exit_barrier_open, entry_reject,
        input  entry_state_dbg, exit_state_dbg
`ifdef PARKING_GATE_EVENT_COUNT_EN
        , input n_entered, n_exited, n_rejected
`endif
    );

    modport slave (
        input  entry_sense, entry_uni_tag, exit_sense, exit_uni_tag,
        input  uni_is_vacated_space, is_vacated_space,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output entry_barrier_open, exit_barrier_open, entry_reject,
        output entry_state_dbg, exit_state_dbg
`ifdef PARKING_GATE_EVENT_COUNT_EN
        , output n_entered, n_exited, n_rejected
`endif
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking gate front-end: debounces entry/exit loops, decides admission, drives barriers
// and emits per-vehicle events. PARKING_GATE_EVENT_COUNT_EN adds saturating event counters.
module parking_gate_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GUARD_CYCLES    = 2
`ifdef PARKING_GATE_EVENT_COUNT_EN
    , parameter int CNT_W         = 16
`endif
) (
    input logic           clk,
    input logic           rst,
    parking_gate_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int GD_W = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [2:0] {ENT_IDLE, ENT_DECIDE, ENT_OPEN, ENT_REJECT, ENT_GUARD} entry_state_t;
    typedef enum logic [1:0] {EXT_IDLE, EXT_OPEN, EXT_GUARD} exit_state_t;

    // Index 0 is the entry loop, index 1 the exit loop.
    logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d, level_q, level_d;
    logic [1:0]      rise, fall;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    entry_state_t    entry_state_q, entry_state_d;
    logic            entry_tag_q, entry_tag_d;
    logic [GD_W-1:0] entry_guard_q, entry_guard_d;
    logic            car_entered_q, car_entered_d;
    logic            uni_entered_q, uni_entered_d;
    logic            entry_open_q, entry_open_d;
    logic            entry_reject_q, entry_reject_d;

    exit_state_t     exit_state_q, exit_state_d;
    logic            exit_tag_q, exit_tag_d;
    logic [GD_W-1:0] exit_guard_q, exit_guard_d;
    logic            car_exited_q, car_exited_d;
    logic            uni_exited_q, uni_exited_d;
    logic            exit_open_q, exit_open_d;

    // Rise/fall are the cycles in which the debounced level actually flips.
    always_comb begin
        sync1_d     = {bus.exit_sense, bus.entry_sense};
        sync2_d     = sync1_q;
        level_d     = level_q;
        rise        = '0;
        fall        = '0;
        db_cnt_d[0] = '0;
        db_cnt_d[1] = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                    rise[i]    = sync2_q[i];
                    fall[i]    = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        entry_state_d  = entry_state_q;
        entry_tag_d    = entry_tag_q;
        entry_guard_d  = entry_guard_q;
        car_entered_d  = 1'b0;
        uni_entered_d  = 1'b0;
        entry_open_d   = 1'b0;
        entry_reject_d = 1'b0;
        case (entry_state_q)
            ENT_IDLE: if (rise[0]) begin
                entry_state_d = ENT_DECIDE;
                entry_tag_d   = bus.entry_uni_tag;
            end
            ENT_DECIDE: begin
                if (entry_tag_q ? bus.uni_is_vacated_space : bus.is_vacated_space) begin
                    entry_state_d = ENT_OPEN;
                end else begin
                    entry_state_d  = ENT_REJECT;
                    entry_reject_d = 1'b1;
                end
            end
            ENT_OPEN: begin
                if (fall[0]) begin
                    entry_state_d = ENT_GUARD;
                    entry_guard_d = GD_W'(GUARD_CYCLES - 1);
                    car_entered_d = 1'b1;
                    uni_entered_d = entry_tag_q;
                end else begin
                    entry_open_d = 1'b1;
                end
            end
            ENT_REJECT: if (fall[0]) begin
                entry_state_d = ENT_GUARD;
                entry_guard_d = GD_W'(GUARD_CYCLES - 1);
            end
            ENT_GUARD: begin
                if (entry_guard_q == '0) entry_state_d = ENT_IDLE;
                else                     entry_guard_d = entry_guard_q - GD_W'(1);
            end
            default: entry_state_d = ENT_IDLE;
        endcase
    end

    always_comb begin
        exit_state_d = exit_state_q;
        exit_tag_d   = exit_tag_q;
        exit_guard_d = exit_guard_q;
        car_exited_d = 1'b0;
        uni_exited_d = 1'b0;
        exit_open_d  = 1'b0;
        case (exit_state_q)
            EXT_IDLE: if (rise[1]) begin
                exit_state_d = EXT_OPEN;
                exit_tag_d   = bus.exit_uni_tag;
            end
            EXT_OPEN: begin
                if (fall[1]) begin
                    exit_state_d = EXT_GUARD;
                    exit_guard_d = GD_W'(GUARD_CYCLES - 1);
                    car_exited_d = 1'b1;
                    uni_exited_d = exit_tag_q;
                end else begin
                    exit_open_d = 1'b1;
                end
            end
            EXT_GUARD: begin
                if (exit_guard_q == '0) exit_state_d = EXT_IDLE;
                else                    exit_guard_d = exit_guard_q - GD_W'(1);
            end
            default: exit_state_d = EXT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            level_q        <= '0;
            db_cnt_q[0]    <= '0;
            db_cnt_q[1]    <= '0;
            entry_state_q  <= ENT_IDLE;
            entry_tag_q    <= 1'b0;
            entry_guard_q  <= '0;
            car_entered_q  <= 1'b0;
            uni_entered_q  <= 1'b0;
            entry_open_q   <= 1'b0;
            entry_reject_q <= 1'b0;
            exit_state_q   <= EXT_IDLE;
            exit_tag_q     <= 1'b0;
            exit_guard_q   <= '0;
            car_exited_q   <= 1'b0;
            uni_exited_q   <= 1'b0;
            exit_open_q    <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            level_q        <= level_d;
            db_cnt_q[0]    <= db_cnt_d[0];
            db_cnt_q[1]    <= db_cnt_d[1];
            entry_state_q  <= entry_state_d;
            entry_tag_q    <= entry_tag_d;
            entry_guard_q  <= entry_guard_d;
            car_entered_q  <= car_entered_d;
            uni_entered_q  <= uni_entered_d;
            entry_open_q   <= entry_open_d;
            entry_reject_q <= entry_reject_d;
            exit_state_q   <= exit_state_d;
            exit_tag_q     <= exit_tag_d;
            exit_guard_q   <= exit_guard_d;
            car_exited_q   <= car_exited_d;
            uni_exited_q   <= uni_exited_d;
            exit_open_q    <= exit_open_d;
        end
    end

    assign bus.car_entered        = car_entered_q;
    assign bus.is_uni_car_entered = uni_entered_q;
    assign bus.car_exited         = car_exited_q;
    assign bus.is_uni_car_exited  = uni_exited_q;
    assign bus.entry_barrier_open = entry_open_q;
    assign bus.exit_barrier_open  = exit_open_q;
    assign bus.entry_reject       = entry_reject_q;
    assign bus.entry_state_dbg    = entry_state_q;
    assign bus.exit_state_dbg     = exit_state_q;

`ifdef PARKING_GATE_EVENT_COUNT_EN
    logic [CNT_W-1:0] n_entered_q, n_entered_d;
    logic [CNT_W-1:0] n_exited_q, n_exited_d;
    logic [CNT_W-1:0] n_rejected_q, n_rejected_d;

    // Counters advance in the same cycle the corresponding pulse is registered.
    always_comb begin
        n_entered_d  = n_entered_q;
        n_exited_d   = n_exited_q;
        n_rejected_d = n_rejected_q;
        if (car_entered_d && !(&n_entered_q))   n_entered_d  = n_entered_q + CNT_W'(1);
        if (car_exited_d && !(&n_exited_q))     n_exited_d   = n_exited_q + CNT_W'(1);
        if (entry_reject_d && !(&n_rejected_q)) n_rejected_d = n_rejected_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_entered_q  <= '0;
            n_exited_q   <= '0;
            n_rejected_q <= '0;
        end else begin
            n_entered_q  <= n_entered_d;
            n_exited_q   <= n_exited_d;
            n_rejected_q <= n_rejected_d;
        end
    end

    assign bus.n_entered  = n_entered_q;
    assign bus.n_exited   = n_exited_q;
    assign bus.n_rejected = n_rejected_q;
`endif
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: vector table, corner sequences and a randomized run
// against a behavioural model; counter checks when PARKING_GATE_EVENT_COUNT_EN is defined.
module tb_parking_gate_ctrl;
    localparam int DEB = 4;
    localparam int GRD = 2;

    localparam logic [6:0] CE = 7'h40, UE = 7'h20, CX = 7'h10, UX = 7'h08;
    localparam logic [6:0] EB = 7'h04, XB = 7'h02, RJ = 7'h01, NONE = 7'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef PARKING_GATE_EVENT_COUNT_EN
    localparam int CW = 2;
    parking_gate_if #(.CNT_W(CW)) bus_if ();
`else
    parking_gate_if bus_if ();
`endif

    parking_gate_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .GUARD_CYCLES(GRD)
`ifdef PARKING_GATE_EVENT_COUNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       r, es, et, xs, xt, uv, gv;
        int         n;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic es, input logic et, input logic xs,
                                input logic xt, input logic uv, input logic gv, input int n,
                                input logic [6:0] exp);
        vec_t v;
        v.r = r; v.es = es; v.et = et; v.xs = xs; v.xt = xt; v.uv = uv; v.gv = gv;
        v.n = n; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] dut_outs();
        return {bus_if.car_entered, bus_if.is_uni_car_entered, bus_if.car_exited,
                bus_if.is_uni_car_exited, bus_if.entry_barrier_open, bus_if.exit_barrier_open,
                bus_if.entry_reject};
    endfunction

    task automatic check_outs(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = dut_outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b (ce ue cx ux eb xb rj)", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic es, input logic et, input logic xs,
                         input logic xt, input logic uv, input logic gv);
        rst                         = r;
        bus_if.entry_sense          = es;
        bus_if.entry_uni_tag        = et;
        bus_if.exit_sense           = xs;
        bus_if.exit_uni_tag         = xt;
        bus_if.uni_is_vacated_space = uv;
        bus_if.is_vacated_space     = gv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a loop's sample reaches the debouncer two edges after it is
    // seen; the level flips once the last DEB samples all disagree with it.
    localparam int P_IDLE = 0, P_DECIDE = 1, P_ADMIT = 2, P_REFUSE = 3, P_GUARD = 4;
    logic           m_s1 [2];
    logic           m_s2 [2];
    logic           m_lvl[2];
    logic [DEB-1:0] m_win[2];
    int             m_phase[2];
    int             m_left [2];
    logic           m_tag  [2];
    logic [6:0]     m_exp;

    task automatic model_edge();
        logic raw[2];
        logic smp;
        logic up[2];
        logic down[2];
        raw[0] = bus_if.entry_sense;
        raw[1] = bus_if.exit_sense;
        m_exp  = NONE;
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                m_s1[g] = 0; m_s2[g] = 0; m_lvl[g] = 0; m_win[g] = '0;
                m_phase[g] = P_IDLE; m_left[g] = 0; m_tag[g] = 0;
            end
            return;
        end
        for (int g = 0; g < 2; g++) begin
            smp      = m_s2[g];
            m_s2[g]  = m_s1[g];
            m_s1[g]  = raw[g];
            m_win[g] = {m_win[g][DEB-2:0], smp};
            up[g]    = 0;
            down[g]  = 0;
            if (m_win[g] == {DEB{~m_lvl[g]}}) begin
                m_lvl[g] = ~m_lvl[g];
                up[g]    = m_lvl[g];
                down[g]  = ~m_lvl[g];
            end
        end
        case (m_phase[0])
            P_IDLE:   if (up[0]) begin m_phase[0] = P_DECIDE; m_tag[0] = bus_if.entry_uni_tag; end
            P_DECIDE: begin
                if (m_tag[0] ? bus_if.uni_is_vacated_space : bus_if.is_vacated_space)
                    m_phase[0] = P_ADMIT;
                else begin
                    m_phase[0] = P_REFUSE;
                    m_exp |= RJ;
                end
            end
            P_ADMIT: begin
                if (down[0]) begin
                    m_exp |= CE | (m_tag[0] ? UE : NONE);
                    m_phase[0] = P_GUARD; m_left[0] = GRD;
                end else m_exp |= EB;
            end
            P_REFUSE: if (down[0]) begin m_phase[0] = P_GUARD; m_left[0] = GRD; end
            default: begin
                m_left[0]--;
                if (m_left[0] == 0) m_phase[0] = P_IDLE;
            end
        endcase
        case (m_phase[1])
            P_IDLE: if (up[1]) begin m_phase[1] = P_ADMIT; m_tag[1] = bus_if.exit_uni_tag; end
            P_ADMIT: begin
                if (down[1]) begin
                    m_exp |= CX | (m_tag[1] ? UX : NONE);
                    m_phase[1] = P_GUARD; m_left[1] = GRD;
                end else m_exp |= XB;
            end
            default: begin
                m_left[1]--;
                if (m_left[1] == 0) m_phase[1] = P_IDLE;
            end
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen_at;
        int   opened;
        int   e_hold, x_hold;
        logic es_r, xs_r;

        drive(1, 0, 0, 0, 0, 0, 0);

        //             r es et xs xt uv gv  n  expected
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, NONE));       // reset
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 7, NONE));       // uni arrival, debouncing
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 13, EB));        // opens 8 after raise
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 5, EB));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, CE | UE));    // 6 after drop
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 6, NONE));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 6, NONE));       // non-uni, no general space
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, RJ));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 10, NONE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8, NONE));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 6, NONE));       // exit vehicle, tag 0
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, XB));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 0, 3, XB));        // 3-cycle entry high glitch
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 8, XB));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 3, XB));        // 3-cycle exit low glitch
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 8, XB));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 7, XB));        // uni entry while exit occupied
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 4, EB | XB));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 5, EB | XB));   // both leave, live tags swapped
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, CE | UE | CX));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4, NONE));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, NONE));       // non-uni admitted
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, EB));         // flags drop, no revoke
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, NONE));       // reset mid-passage
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, NONE));       // fresh arrival after reset
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, EB));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, EB));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, CE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, NONE));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].es, tbl[i].et, tbl[i].xs, tbl[i].xt, tbl[i].uv, tbl[i].gv);
            for (int k = 0; k < tbl[i].n; k++) begin
                tick();
                check_outs($sformatf("vec%0d.t%0d", i, k), tbl[i].exp);
            end
        end

        // Uni vehicle with only general space free is refused 7 cycles after arrival.
        drive(0, 1, 1, 0, 0, 0, 1);
        seen_at = -1;
        opened  = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus_if.entry_reject && seen_at < 0) seen_at = k;
            if (bus_if.entry_barrier_open) opened = 1;
        end
        check_int("uni_refused_latency", seen_at, 7);
        check_int("uni_refused_never_open", opened, 0);
        drive(0, 0, 1, 0, 0, 0, 1);
        repeat (10) tick();

`ifdef PARKING_GATE_EVENT_COUNT_EN
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check_int("cnt_entered_reset", int'(bus_if.n_entered), 0);
        for (int c = 0; c < 5; c++) begin
            drive(0, 1, 1, 0, 0, 1, 0);
            repeat (10) tick();
            drive(0, 0, 1, 0, 0, 1, 0);
            repeat (10) tick();
        end
        check_int("cnt_entered_saturated", int'(bus_if.n_entered), 3);
        check_int("cnt_exited_idle", int'(bus_if.n_exited), 0);
        check_int("cnt_rejected_idle", int'(bus_if.n_rejected), 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check_int("cnt_entered_cleared", int'(bus_if.n_entered), 0);
`endif

        // Randomized run against the behavioural model.
        e_hold = 0;
        x_hold = 0;
        es_r   = 0;
        xs_r   = 0;
        for (int c = 0; c < 3000; c++) begin
            if (e_hold == 0) begin es_r = ~es_r; e_hold = $urandom_range(1, 14); end
            else e_hold--;
            if (x_hold == 0) begin xs_r = ~xs_r; x_hold = $urandom_range(1, 14); end
            else x_hold--;
            drive((c < 2) || ($urandom_range(0, 399) == 0), es_r, 1'($urandom_range(0, 1)),
                  xs_r, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 6));
            @(posedge clk);
            model_edge();
            #1;
            check_outs($sformatf("rand%0d", c), m_exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Gate front-end directly upstream of the parking occupancy counter.
- Debounces raw entry/exit loop-detector inputs and latches each vehicle's university tag.
- Decides admission from the occupancy counter's vacancy flags, drives entry and exit barriers, and emits the single-cycle car_entered/is_uni_car_entered and car_exited/is_uni_car_exited events the counter consumes.
- One event per physical vehicle passage. No event for rejected vehicles.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed for a sensor level change (min 2).
- GUARD_CYCLES, 2: hold-off after each completed passage or rejection before a new arrival is accepted (min 1).
- CNT_W, 16: width of the optional event counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- entry_sense  in  1  raw entry loop detector (async)
- entry_uni_tag  in  1  university card present at entry; sampled at arrival qualification
- exit_sense  in  1  raw exit loop detector (async)
- exit_uni_tag  in  1  university card present at exit; sampled at arrival qualification
- uni_is_vacated_space  in  1  from occupancy counter: university space free
- is_vacated_space  in  1  from occupancy counter: general space free
- car_entered  out  1  one-cycle pulse: vehicle passed entry barrier
- is_uni_car_entered  out  1  tag of that vehicle; valid only with car_entered, else 0
- car_exited  out  1  one-cycle pulse: vehicle passed exit barrier
- is_uni_car_exited  out  1  tag of that vehicle; valid only with car_exited, else 0
- entry_barrier_open  out  1  entry barrier drive, registered
- exit_barrier_open  out  1  exit barrier drive, registered
- entry_reject  out  1  one-cycle pulse: arrival refused, no space
- (EVENT_COUNT_EN only) n_entered, n_exited, n_rejected  out  CNT_W  saturating counters

Behaviour:
- Reset:
  - All outputs 0, both FSMs IDLE, debounced levels 0, counters cleared.
  - Reset mid-passage abandons the passage with no pulse. A vehicle still on a loop at reset release is treated as a fresh arrival.
- Input conditioning:
  - Each sense input passes through a 2-flop synchroniser.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it.
  - Total latency from raw change to debounced change: 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES samples are ignored; the debounce counter clears on any agreeing sample.
- Entry FSM states: IDLE, DECIDE, OPEN, REJECT, GUARD.
  - IDLE -> DECIDE on debounced rise; entry_uni_tag is latched in that cycle.
  - DECIDE (1 cycle), admit rule: uni vehicle admitted iff uni_is_vacated_space=1; non-uni vehicle admitted iff is_vacated_space=1. Flags are sampled in the DECIDE cycle.
  - DECIDE -> OPEN if admitted. entry_barrier_open=1 from the next cycle and held through OPEN.
  - DECIDE -> REJECT if not admitted. entry_reject pulses for 1 cycle; barrier stays closed.
  - OPEN -> GUARD on debounced fall. In the GUARD entry cycle: car_entered=1, is_uni_car_entered=latched tag, entry_barrier_open=0.
  - REJECT -> GUARD on debounced fall, with no event.
  - GUARD -> IDLE after GUARD_CYCLES cycles. Arrivals during GUARD are ignored until the debounced level rises again after IDLE.
- Exit FSM states: IDLE, OPEN, GUARD.
  - IDLE -> OPEN on debounced rise; exit_uni_tag latched, exit_barrier_open=1 the next cycle.
  - OPEN -> GUARD on debounced fall, with car_exited pulse and is_uni_car_exited=latched tag.
  - Exit never rejects. Underflow protection belongs to the occupancy counter.
- Simultaneous events:
  - Entry and exit FSMs are independent.
  - car_entered and car_exited may pulse in the same cycle; the counter resolves the order.
  - Vacancy flags changing during OPEN do not revoke an admission.
- Each pulse is exactly 1 cycle. Pulses never occur back-to-back on the same gate, because GUARD_CYCLES >= 1.

Optional Feature:
- Macro: PARKING_GATE_EVENT_COUNT_EN.
- Defined:
  - n_entered, n_exited and n_rejected increment on car_entered, car_exited and entry_reject respectively.
  - Each counter saturates at 2^CNT_W-1.
  - Counters clear on rst.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, GUARD_CYCLES=2):
- Reset, then entry_sense high for 20 cycles with uni_tag=1 and uni_is_vacated_space=1:
  - barrier opens 8 cycles after the raise (6 debounce + DECIDE + register).
  - Drop sense: car_entered and is_uni_car_entered pulse once, 6 cycles after the drop; barrier closes the same cycle.
- Non-uni arrival with is_vacated_space=0 -> entry_reject pulses 1 cycle; barrier never opens; no car_entered; returns to IDLE 2 cycles after debounced departure.
- 3-cycle high glitch on entry_sense, then 3-cycle low glitch while a vehicle sits on the exit loop -> no state change, no pulses, exit barrier stays open.
- Entry and exit vehicles depart on the same raw cycle -> car_entered and car_exited pulse in the same cycle, each with its own latched tag (1 and 0).
- rst asserted while entry is in OPEN with sense still high -> barrier 0 next cycle and no pulse; after release, a new full debounce completes and the barrier reopens.
- With PARKING_GATE_EVENT_COUNT_EN and CNT_W=2: 5 admitted entries -> n_entered=3 (saturated); then rst -> 0.
